aes_round_ctrl: RTL and testbench

AES_ROUND_CTRL -- requirements
Module: aes_round_ctrl

---
 rtl/aes_round_ctrl_if.sv | 29 ++
 rtl/aes_round_ctrl.sv | 97 +++++++++
 tb/tb_aes_round_ctrl.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/aes_round_ctrl_if.sv
// Control/status bundle between the AES round controller and its environment
// (start/abort requester and the round-constant stage).
interface aes_round_ctrl_if;
  logic       StartxSI;
  logic       AbortxSI;
  logic       RconLastxSI;
  logic       RconFinishedxSI;
  logic       RconNextxSO;
  logic       RconActivexSO;
  logic       LoadxSO;
  logic       SboxEnxSO;
  logic       MixColEnxSO;
  logic       BusyxSO;
  logic       DonexSO;
  logic       ErrorxSO;
  logic [3:0] RoundxDO;

  modport master (
    output StartxSI, AbortxSI, RconLastxSI, RconFinishedxSI,
    input  RconNextxSO, RconActivexSO, LoadxSO, SboxEnxSO, MixColEnxSO,
           BusyxSO, DonexSO, ErrorxSO, RoundxDO
  );

  modport slave (
    input  StartxSI, AbortxSI, RconLastxSI, RconFinishedxSI,
    output RconNextxSO, RconActivexSO, LoadxSO, SboxEnxSO, MixColEnxSO,
           BusyxSO, DonexSO, ErrorxSO, RoundxDO
  );
endinterface

// File: rtl/aes_round_ctrl.sv
// AES round sequencer: steps ten rounds of CYC_PER_ROUND cycles, drives the
// external rcon stage and cross-checks its last/finished flags.
module aes_round_ctrl #(
  parameter int unsigned CYC_PER_ROUND = 20,
  parameter int unsigned RCON_CYC      = 0
) (
  input  logic           ClkxCI,
  input  logic           RstxRI,
  aes_round_ctrl_if.slave bus
);

  typedef enum logic [2:0] {IDLE, LOAD, ROUND, DONE, FLUSH} state_e;

  localparam logic [4:0] CNT_LAST = 5'(CYC_PER_ROUND - 1);
  localparam logic [4:0] CNT_RCON = 5'(RCON_CYC);

  state_e     state_q, state_d;
  logic [4:0] CntxDP, cnt_d;
  logic [3:0] RndxDP, rnd_d;
  logic       err_q, err_d;
  logic       end_of_round;

  assign end_of_round = (state_q == ROUND) && (CntxDP == CNT_LAST);

  always_comb begin
    state_d = state_q;
    cnt_d   = CntxDP;
    rnd_d   = RndxDP;
    err_d   = err_q;
    unique case (state_q)
      IDLE: begin
        if (bus.StartxSI && !bus.AbortxSI) begin
          state_d = LOAD;
          if (!bus.RconFinishedxSI) err_d = 1'b1;
        end
      end
      LOAD: begin
        cnt_d   = '0;
        rnd_d   = 4'd1;
        state_d = ROUND;
      end
      ROUND: begin
        cnt_d = end_of_round ? '0 : CntxDP + 5'd1;
        // rcon reaching its last value early is a sequencing fault in any cycle
        if (bus.RconLastxSI && (RndxDP != 4'd10)) begin
          err_d   = 1'b1;
          state_d = FLUSH;
        end else if (end_of_round) begin
          if (bus.RconLastxSI) begin
            state_d = DONE;
          end else if (RndxDP == 4'd10) begin
            err_d   = 1'b1;
            state_d = FLUSH;
          end else begin
            rnd_d = RndxDP + 4'd1;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
        if (!bus.RconFinishedxSI) err_d = 1'b1;
      end
      FLUSH: begin
        if (bus.RconFinishedxSI) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (bus.AbortxSI && (state_q inside {LOAD, ROUND, DONE})) state_d = FLUSH;
  end

  always_ff @(posedge ClkxCI) begin
    if (RstxRI) begin
      state_q <= IDLE;
      CntxDP  <= '0;
      RndxDP  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      CntxDP  <= cnt_d;
      RndxDP  <= rnd_d;
      err_q   <= err_d;
    end
  end

  // FLUSH keeps stepping rcon until it is back at its idle value
  assign bus.RconNextxSO   = (state_q == LOAD) || end_of_round ||
                             ((state_q == FLUSH) && !bus.RconFinishedxSI);
  assign bus.RconActivexSO = (state_q == ROUND) && (CntxDP == CNT_RCON);
  assign bus.LoadxSO       = (state_q == LOAD);
  assign bus.SboxEnxSO     = (state_q == ROUND);
  assign bus.MixColEnxSO   = (state_q == ROUND) && !bus.RconLastxSI;
  assign bus.BusyxSO       = (state_q != IDLE);
  assign bus.DonexSO       = (state_q == DONE);
  assign bus.ErrorxSO      = err_q;
  assign bus.RoundxDO      = (state_q == ROUND) ? RndxDP : '0;

endmodule

// File: tb/tb_aes_round_ctrl.sv
// Directed bench for aes_round_ctrl with a behavioural rcon stage attached.
module tb_aes_round_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic abort = 1'b0;
  logic stuck_last = 1'b0;
  logic force_unfin = 1'b0;
  logic [7:0] rcon_q;

  int n_checks = 0;
  int n_fail = 0;

  int         mon_cyc;
  int         n_act, n_done, n_next;
  logic [7:0] act_val [16];
  int         act_cyc [16];
  int         done_cyc [4];
  logic [15:0] mix_off;

  logic [7:0] rc_exp [10] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
                              8'h20, 8'h40, 8'h80, 8'h1B, 8'h36};

  aes_round_ctrl_if bus ();

  aes_round_ctrl #(.CYC_PER_ROUND(20), .RCON_CYC(0)) dut (
    .ClkxCI (clk),
    .RstxRI (rst),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  assign bus.StartxSI        = start;
  assign bus.AbortxSI        = abort;
  assign bus.RconLastxSI     = (rcon_q == 8'h36) && !stuck_last;
  assign bus.RconFinishedxSI = (rcon_q == 8'h6C) && !force_unfin;

  function automatic logic [7:0] xtime(input logic [7:0] v);
    return {v[6:0], 1'b0} ^ (v[7] ? 8'h1B : 8'h00);
  endfunction

  // rcon stage model: idle 0x6C, 0x6C -> 0x01, then GF(2^8) doubling
  always @(posedge clk) begin
    if (rst) rcon_q <= 8'h6C;
    else if (bus.RconNextxSO) rcon_q <= (rcon_q == 8'h6C) ? 8'h01 : xtime(rcon_q);
  end

  always @(negedge clk) begin
    mon_cyc++;
    if (bus.RconActivexSO && n_act < 16) begin
      act_val[n_act] = rcon_q;
      act_cyc[n_act] = mon_cyc;
      n_act++;
    end
    if (bus.DonexSO && n_done < 4) begin
      done_cyc[n_done] = mon_cyc;
      n_done++;
    end
    if (bus.RconNextxSO) n_next++;
    if (bus.SboxEnxSO && !bus.MixColEnxSO) mix_off[bus.RoundxDO] = 1'b1;
  end

  function automatic logic [11:0] outs();
    return {bus.RconNextxSO, bus.RconActivexSO, bus.LoadxSO, bus.SboxEnxSO,
            bus.MixColEnxSO, bus.BusyxSO, bus.DonexSO, bus.ErrorxSO, bus.RoundxDO};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic mon_clear();
    mon_cyc = 0;
    n_act   = 0;
    n_done  = 0;
    n_next  = 0;
    mix_off = '0;
    for (int i = 0; i < 16; i++) begin
      act_val[i] = '0;
      act_cyc[i] = 0;
    end
    for (int i = 0; i < 4; i++) done_cyc[i] = 0;
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
    #2;
  endtask

  // start sampled at edge k; monitor cycle 1 is then the LOAD cycle
  task automatic start_pulse();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    mon_clear();
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk);
    rst = 1'b1;
    wait_cycles(2);
    check($sformatf("%s_hold", tag), outs(), 12'h000);
    rst = 1'b0;
    wait_cycles(1);
    check($sformatf("%s_after", tag), outs(), 12'h000);
    check($sformatf("%s_rcon", tag), rcon_q, 8'h6C);
  endtask

  task automatic check_run(input string tag, input logic exp_err);
    wait_cycles(210);
    check($sformatf("%s_ndone", tag), n_done, 1);
    check($sformatf("%s_donecyc", tag), done_cyc[0], 202);
    check($sformatf("%s_nact", tag), n_act, 10);
    for (int i = 0; i < 10; i++) begin
      check($sformatf("%s_rcon%0d", tag, i + 1), act_val[i], rc_exp[i]);
      check($sformatf("%s_actcyc%0d", tag, i + 1), act_cyc[i], 2 + 20 * i);
    end
    check($sformatf("%s_mixoff", tag), mix_off, 16'h0400);
    check($sformatf("%s_err", tag), bus.ErrorxSO, exp_err);
    check($sformatf("%s_idle", tag), bus.BusyxSO, 1'b0);
  endtask

  initial begin
    mon_clear();
    do_reset("reset");

    // nominal encryption
    start_pulse();
    wait_cycles(1);
    check("load_cycle", outs(), 12'b1010_0100_0000);
    wait_cycles(1);
    check("round1_first", outs(), 12'b0101_1100_0001);
    check_run("nominal", 1'b0);

    // abort in round 4, counter 7
    start_pulse();
    wait_cycles(69);
    check("abort_round", bus.RoundxDO, 4'd4);
    check("abort_rcon", rcon_q, 8'h08);
    abort = 1'b1;
    @(posedge clk);
    #1;
    abort = 1'b0;
    begin
      int snap;
      snap = n_next;
      wait_cycles(8);
      check("flush_last", {bus.RconNextxSO, bus.BusyxSO, bus.RoundxDO}, 6'b01_0000);
      wait_cycles(1);
      check("flush_idle", bus.BusyxSO, 1'b0);
      wait_cycles(20);
      check("flush_npulse", n_next - snap, 7);
    end
    check("abort_nodone", n_done, 0);
    check("abort_rcon_idle", rcon_q, 8'h6C);
    check("abort_err", bus.ErrorxSO, 1'b0);

    // start held high: back-to-back encryptions
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    mon_clear();
    wait_cycles(405);
    start = 1'b0;
    wait_cycles(5);
    check("b2b_ndone", n_done, 2);
    check("b2b_done1", done_cyc[0], 202);
    check("b2b_done2", done_cyc[1], 405);
    check("b2b_gap", done_cyc[1] - done_cyc[0], 203);
    check("b2b_idle", bus.BusyxSO, 1'b0);
    check("b2b_err", bus.ErrorxSO, 1'b0);

    // last flag stuck low
    stuck_last = 1'b1;
    start_pulse();
    wait_cycles(201);
    check("stuck_eor", outs(), 12'b1001_1100_1010);
    wait_cycles(1);
    check("stuck_flush", outs(), 12'b0000_0101_0000);
    wait_cycles(1);
    check("stuck_idle", outs(), 12'b0000_0001_0000);
    wait_cycles(10);
    check("stuck_nodone", n_done, 0);
    stuck_last = 1'b0;
    do_reset("reset2");

    // start while rcon not at idle value
    force_unfin = 1'b1;
    start_pulse();
    force_unfin = 1'b0;
    wait_cycles(1);
    check("unfin_err_load", {bus.LoadxSO, bus.ErrorxSO}, 2'b11);
    check_run("unfin", 1'b1);
    do_reset("reset3");

    // reset in the middle of a round, then a clean run
    start_pulse();
    wait_cycles(50);
    check("midrst_busy", bus.RoundxDO, 4'd3);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    wait_cycles(1);
    check("midrst_idle", outs(), 12'h000);
    start_pulse();
    check_run("after_rst", 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
